// File: rtl/gsim_pkg.sv
// Shared definitions for the Gauss-Seidel sequencer: state encoding, memory
// layout strides and the address helpers used by the top level.
package gsim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } gsim_state_e;

    localparam int MAT_STRIDE = 17;
    localparam int X_STRIDE   = 16;
    localparam int NROW       = 16;
    localparam int B_OFFSET   = 16;

    // Read address of read number idx within matrix mat: b first, then rows 0..15 cycling.
    function automatic logic [9:0] rd_addr_f(input logic [4:0] mat, input logic [8:0] idx);
        logic [9:0] base;
        logic [3:0] row;
        base = 10'(mat) * 10'(MAT_STRIDE);
        row  = 4'(idx - 9'd1);
        if (idx == 9'd0) begin
            rd_addr_f = base + 10'(B_OFFSET);
        end else begin
            rd_addr_f = base + {6'd0, row};
        end
    endfunction

    // Result address of x element sel for matrix mat.
    function automatic logic [8:0] x_addr_f(input logic [4:0] mat, input logic [3:0] sel);
        x_addr_f = 9'(mat) * 9'(X_STRIDE) + {5'd0, sel};
    endfunction

endpackage

// File: rtl/gsim_rd_credit.sv
// Outstanding-read tracker: counts accepted-but-unreturned reads, tells the
// sequencer whether another request may be raised next cycle, and numbers the
// in-order return beats of the current matrix.
module gsim_rd_credit #(
    parameter int MAX_OUTST = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clr,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [2:0] o_cnt_next,
    output logic       o_issue_ok,
    output logic [8:0] o_beat_idx
);

    localparam logic [2:0] MAX_C = 3'(MAX_OUTST);

    logic [2:0] cnt_q, cnt_d;
    logic [8:0] beat_q, beat_d;
    logic       dec_ok_s;

    // Next outstanding count and beat index; a simultaneous accept and return cancel.
    always_comb begin
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        dec_ok_s = i_dec && ((cnt_q != 3'd0) || i_inc);
        if (i_clr) begin
            cnt_d  = 3'd0;
            beat_d = 9'd0;
        end else begin
            case ({i_inc, dec_ok_s})
                2'b10:   cnt_d = cnt_q + 3'd1;
                2'b01:   cnt_d = cnt_q - 3'd1;
                default: cnt_d = cnt_q;
            endcase
            if (dec_ok_s) begin
                beat_d = beat_q + 9'd1;
            end else begin
                beat_d = beat_q;
            end
        end
    end

    // Credit and beat registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q  <= 3'd0;
            beat_q <= 9'd0;
        end else begin
            cnt_q  <= cnt_d;
            beat_q <= beat_d;
        end
    end

    assign o_cnt_next = cnt_d;
    assign o_issue_ok = (cnt_d < MAX_C);
    assign o_beat_idx = beat_q;

endmodule

// File: rtl/gsim_seq.sv
// Gauss-Seidel matrix sequencer: streams b and ITER sweeps of matrix rows from
// memory with a bounded number of reads in flight, steers return beats to the
// datapath, then writes the 16 x results. Optional cycle counter enabled by
// defining GSIM_SEQ_PERF_CNT_EN.
module gsim_seq
    import gsim_pkg::*;
#(
    parameter int ITER      = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_module_en,
    input  logic [4:0]  i_matrix_num,
    output logic        o_proc_done,
    output logic        o_mem_rreq,
    output logic [9:0]  o_mem_addr,
    input  logic        i_mem_rrdy,
    input  logic        i_mem_dout_vld,
    output logic        o_dp_ld_b,
    output logic        o_dp_row_vld,
    output logic [3:0]  o_dp_row_idx,
    output logic        o_x_wen,
    output logic [8:0]  o_x_addr,
    output logic [3:0]  o_x_sel
`ifdef GSIM_SEQ_PERF_CNT_EN
    ,
    output logic [19:0] o_cycle_cnt
`endif
);

    // Index of the final read of a matrix (b plus NROW*ITER rows).
    localparam logic [8:0] LAST_RD = 9'(NROW * ITER);

    gsim_state_e state_q, state_d;
    logic [4:0]  mat_q, mat_d;
    logic [4:0]  num_q, num_d;
    logic [8:0]  rd_cnt_q, rd_cnt_d;
    logic        rreq_q, rreq_d;
    logic [9:0]  addr_q, addr_d;
    logic        x_wen_q, x_wen_d;
    logic [3:0]  x_sel_q, x_sel_d;
    logic [8:0]  x_addr_q, x_addr_d;
    logic        done_q, done_d;

    logic        active_s;
    logic        accept_s;
    logic        ret_s;
    logic        clr_s;
    logic [2:0]  cnt_next_s;
    logic        issue_ok_s;
    logic [8:0]  beat_idx_s;

    assign active_s = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign accept_s = rreq_q && i_mem_rrdy;
    assign ret_s    = i_mem_dout_vld && active_s;
    assign clr_s    = !active_s || !i_module_en;

    gsim_rd_credit #(
        .MAX_OUTST (MAX_OUTST)
    ) u_rd_credit (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clr      (clr_s),
        .i_inc      (accept_s),
        .i_dec      (ret_s),
        .o_cnt_next (cnt_next_s),
        .o_issue_ok (issue_ok_s),
        .o_beat_idx (beat_idx_s)
    );

    // Sequencer next-state and next-output logic; disabling wins over everything.
    always_comb begin
        state_d  = state_q;
        mat_d    = mat_q;
        num_d    = num_q;
        rd_cnt_d = rd_cnt_q;
        rreq_d   = 1'b0;
        addr_d   = addr_q;
        x_wen_d  = 1'b0;
        x_sel_d  = x_sel_q;
        x_addr_d = x_addr_q;
        done_d   = done_q;
        if (!i_module_en) begin
            state_d  = ST_IDLE;
            mat_d    = 5'd0;
            rd_cnt_d = 9'd0;
            addr_d   = 10'd0;
            x_sel_d  = 4'd0;
            x_addr_d = 9'd0;
            done_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    num_d    = i_matrix_num;
                    mat_d    = 5'd0;
                    rd_cnt_d = 9'd0;
                    if (i_matrix_num == 5'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        addr_d  = rd_addr_f(5'd0, 9'd0);
                        rreq_d  = issue_ok_s;
                    end
                end
                ST_FETCH: begin
                    if (accept_s) begin
                        rd_cnt_d = rd_cnt_q + 9'd1;
                        if (rd_cnt_q == LAST_RD) begin
                            state_d = ST_DRAIN;
                        end else begin
                            addr_d = rd_addr_f(mat_q, rd_cnt_q + 9'd1);
                            rreq_d = issue_ok_s;
                        end
                    end else begin
                        rreq_d = issue_ok_s;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_next_s == 3'd0) begin
                        state_d  = ST_WRITE;
                        x_wen_d  = 1'b1;
                        x_sel_d  = 4'd0;
                        x_addr_d = x_addr_f(mat_q, 4'd0);
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_WRITE: begin
                    if (x_sel_q != 4'd15) begin
                        x_wen_d  = 1'b1;
                        x_sel_d  = x_sel_q + 4'd1;
                        x_addr_d = x_addr_f(mat_q, x_sel_q + 4'd1);
                    end else if ((mat_q + 5'd1) < num_q) begin
                        state_d  = ST_FETCH;
                        mat_d    = mat_q + 5'd1;
                        rd_cnt_d = 9'd0;
                        addr_d   = rd_addr_f(mat_q + 5'd1, 9'd0);
                        rreq_d   = issue_ok_s;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
                ST_DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            mat_q    <= 5'd0;
            num_q    <= 5'd0;
            rd_cnt_q <= 9'd0;
            rreq_q   <= 1'b0;
            addr_q   <= 10'd0;
            x_wen_q  <= 1'b0;
            x_sel_q  <= 4'd0;
            x_addr_q <= 9'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mat_q    <= mat_d;
            num_q    <= num_d;
            rd_cnt_q <= rd_cnt_d;
            rreq_q   <= rreq_d;
            addr_q   <= addr_d;
            x_wen_q  <= x_wen_d;
            x_sel_q  <= x_sel_d;
            x_addr_q <= x_addr_d;
            done_q   <= done_d;
        end
    end

    assign o_proc_done  = done_q;
    assign o_mem_rreq   = rreq_q;
    assign o_mem_addr   = addr_q;
    assign o_x_wen      = x_wen_q;
    assign o_x_sel      = x_sel_q;
    assign o_x_addr     = x_addr_q;
    assign o_dp_ld_b    = ret_s && (beat_idx_s == 9'd0);
    assign o_dp_row_vld = ret_s && (beat_idx_s != 9'd0);
    assign o_dp_row_idx = 4'(beat_idx_s - 9'd1);

`ifdef GSIM_SEQ_PERF_CNT_EN
    logic [19:0] cyc_cnt_q, cyc_cnt_d;

    // Busy-cycle counter: restarts on each new run, saturates rather than wraps.
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if ((state_q == ST_IDLE) && (state_d == ST_FETCH)) begin
            cyc_cnt_d = 20'd0;
        end else if ((state_q != ST_IDLE) && (state_q != ST_DONE) && (cyc_cnt_q != 20'hFFFFF)) begin
            cyc_cnt_d = cyc_cnt_q + 20'd1;
        end else begin
            cyc_cnt_d = cyc_cnt_q;
        end
    end

    // Busy-cycle counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cyc_cnt_q <= 20'd0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign o_cycle_cnt = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_gsim_seq.sv
// Scoreboard bench for gsim_seq: a memory model with configurable latency and
// ready pattern, a reference model that lists expected reads, datapath beats
// and result writes, and a monitor that compares whenever the DUT acts.
module tb_gsim_seq;

    localparam int ITER      = 16;
    localparam int MAX_OUTST = 4;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_module_en;
    logic [4:0]  i_matrix_num;
    logic        o_proc_done;
    logic        o_mem_rreq;
    logic [9:0]  o_mem_addr;
    logic        i_mem_rrdy;
    logic        i_mem_dout_vld;
    logic        o_dp_ld_b;
    logic        o_dp_row_vld;
    logic [3:0]  o_dp_row_idx;
    logic        o_x_wen;
    logic [8:0]  o_x_addr;
    logic [3:0]  o_x_sel;
`ifdef GSIM_SEQ_PERF_CNT_EN
    logic [19:0] o_cycle_cnt;
`endif

    always #5 i_clk = ~i_clk;

    gsim_seq #(.ITER(ITER), .MAX_OUTST(MAX_OUTST)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_module_en    (i_module_en),
        .i_matrix_num   (i_matrix_num),
        .o_proc_done    (o_proc_done),
        .o_mem_rreq     (o_mem_rreq),
        .o_mem_addr     (o_mem_addr),
        .i_mem_rrdy     (i_mem_rrdy),
        .i_mem_dout_vld (i_mem_dout_vld),
        .o_dp_ld_b      (o_dp_ld_b),
        .o_dp_row_vld   (o_dp_row_vld),
        .o_dp_row_idx   (o_dp_row_idx),
        .o_x_wen        (o_x_wen),
        .o_x_addr       (o_x_addr),
        .o_x_sel        (o_x_sel)
`ifdef GSIM_SEQ_PERF_CNT_EN
        ,
        .o_cycle_cnt    (o_cycle_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int exp_rd[$];
    int exp_beat[$];   // 16 = b vector, 0..15 = row index
    int exp_wr[$];     // addr*16 + sel
    int pend[$];       // due cycles of in-flight reads
    int lat       = 2;
    int rr_mode   = 0; // 0: always ready, 1: toggling, 2: random
    int mcyc      = 0;
    int outst     = 0;
    int max_outst = 0;

    function automatic void chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Reference model: what a run of n matrices must produce.
    task automatic build_exp(input int n);
        for (int k = 0; k < n; k++) begin
            exp_rd.push_back(k * 17 + 16);
            exp_beat.push_back(16);
            for (int it = 0; it < ITER; it++) begin
                for (int r = 0; r < 16; r++) begin
                    exp_rd.push_back(k * 17 + r);
                    exp_beat.push_back(r);
                end
            end
            for (int i = 0; i < 16; i++) exp_wr.push_back((k * 16 + i) * 16 + i);
        end
    endtask

    task automatic clear_exp();
        exp_rd.delete();
        exp_beat.delete();
        exp_wr.delete();
    endtask

    // Memory model: accepts on rreq&rrdy, returns in order after lat cycles.
    initial begin
        bit acc, ret;
        i_mem_rrdy     = 1'b0;
        i_mem_dout_vld = 1'b0;
        forever begin
            @(negedge i_clk);
            acc = o_mem_rreq && i_mem_rrdy;
            ret = i_mem_dout_vld;
            @(posedge i_clk);
            #1;
            mcyc++;
            if (ret && pend.size() != 0) void'(pend.pop_front());
            if (acc) pend.push_back(mcyc + lat - 1);
            i_mem_dout_vld = (pend.size() != 0) && (pend[0] <= mcyc);
            case (rr_mode)
                0:       i_mem_rrdy = 1'b1;
                1:       i_mem_rrdy = ~i_mem_rrdy;
                default: i_mem_rrdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares every DUT action against the scoreboard queues.
    initial begin
        bit         acc, ret, prev_stall;
        logic [9:0] prev_addr;
        int         got, e;
        prev_stall = 1'b0;
        prev_addr  = 10'd0;
        forever begin
            @(negedge i_clk);
            acc = o_mem_rreq && i_mem_rrdy;
            ret = i_mem_dout_vld;
            if (o_mem_rreq) begin
                chk("outst_limit", int'(outst < MAX_OUTST), 1);
                chk("rreq_expected", int'(exp_rd.size() != 0), 1);
                if (acc && exp_rd.size() != 0) begin
                    e = exp_rd.pop_front();
                    chk("rd_addr", int'(o_mem_addr), e);
                end
                if (prev_stall) chk("addr_hold", int'(o_mem_addr), int'(prev_addr));
            end
            prev_stall = o_mem_rreq && !i_mem_rrdy;
            prev_addr  = o_mem_addr;
            if (o_dp_ld_b || o_dp_row_vld) begin
                chk("dp_with_vld", int'(ret), 1);
                got = o_dp_ld_b ? (o_dp_row_vld ? 99 : 16) : int'(o_dp_row_idx);
                e   = (exp_beat.size() != 0) ? exp_beat.pop_front() : -1;
                chk("dp_beat", got, e);
            end
            if (o_x_wen) begin
                got = int'(o_x_addr) * 16 + int'(o_x_sel);
                e   = (exp_wr.size() != 0) ? exp_wr.pop_front() : -1;
                chk("x_write", got, e);
            end
            outst = outst + int'(acc) - int'(ret);
            if (outst > max_outst) max_outst = outst;
        end
    end

    task automatic drain_mem();
        for (int c = 0; c < 300; c++) begin
            if (pend.size() == 0) break;
            tick();
        end
        chk("mem_drained", pend.size(), 0);
    endtask

    task automatic run(input int n, input int l, input int mode, input int budget);
        bit ok;
        lat     = l;
        rr_mode = mode;
        build_exp(n);
        i_matrix_num = 5'(n);
        i_module_en  = 1'b1;
        tick(); tick(); tick();
        i_matrix_num = 5'd29;  // must be ignored until the next IDLE
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge i_clk);
            if (o_proc_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_seen", int'(ok), 1);
        tick(); tick();
        chk("done_level", int'(o_proc_done), 1);
        chk("rd_left", exp_rd.size(), 0);
        chk("beat_left", exp_beat.size(), 0);
        chk("wr_left", exp_wr.size(), 0);
        i_module_en = 1'b0;
        tick();
        chk("done_clear", int'(o_proc_done), 0);
        drain_mem();
        clear_exp();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        i_reset      = 1'b1;
        i_module_en  = 1'b1;
        i_matrix_num = 5'd3;
        tick(); tick(); tick();
        chk("rst_rreq", int'(o_mem_rreq), 0);
        chk("rst_addr", int'(o_mem_addr), 0);
        chk("rst_done", int'(o_proc_done), 0);
        chk("rst_wen", int'(o_x_wen), 0);
        chk("rst_xaddr", int'(o_x_addr), 0);
        chk("rst_xsel", int'(o_x_sel), 0);
        i_module_en = 1'b0;
        i_reset     = 1'b0;
        tick();

        // One matrix, always ready, short latency.
        run(1, 2, 0, 3000);
        // Two matrices with toggling ready.
        run(2, 3, 1, 6000);
        // Long latency: credit limit must be reached but never exceeded.
        max_outst = 0;
        run(1, 10, 0, 5000);
        chk("max_outst", max_outst, MAX_OUTST);

        // Zero matrices: done within 2 cycles, no traffic.
        rr_mode      = 0;
        i_matrix_num = 5'd0;
        i_module_en  = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (o_proc_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("zero_done", int'(ok), 1);
        tick(); tick(); tick();
        chk("zero_done_level", int'(o_proc_done), 1);
        i_module_en = 1'b0;
        tick();
        chk("zero_done_clear", int'(o_proc_done), 0);

        // Enable dropped mid-fetch, late returns ignored, then a clean restart.
        lat     = 6;
        rr_mode = 2;
        build_exp(1);
        i_matrix_num = 5'd1;
        i_module_en  = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (exp_rd.size() <= 217) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drop_progress", int'(ok), 1);
        i_module_en = 1'b0;
        tick();
        clear_exp();
        chk("drop_rreq", int'(o_mem_rreq), 0);
        chk("drop_wen", int'(o_x_wen), 0);
        drain_mem();
        run(1, 4, 2, 5000);

        // Reset asserted while writing element 7.
        lat     = 2;
        rr_mode = 0;
        build_exp(1);
        i_matrix_num = 5'd1;
        i_module_en  = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge i_clk);
            if (o_x_wen && o_x_sel == 4'd7) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wr7_seen", int'(ok), 1);
        i_reset     = 1'b1;
        i_module_en = 1'b0;
        tick();
        clear_exp();
        chk("wrst_wen", int'(o_x_wen), 0);
        chk("wrst_xaddr", int'(o_x_addr), 0);
        chk("wrst_xsel", int'(o_x_sel), 0);
        chk("wrst_rreq", int'(o_mem_rreq), 0);
        chk("wrst_addr", int'(o_mem_addr), 0);
        chk("wrst_done", int'(o_proc_done), 0);
        i_reset = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        drain_mem();

        // Randomised runs.
        for (int t = 0; t < 3; t++) begin
            int n, l, m;
            n = $urandom_range(1, 2);
            l = $urandom_range(1, 10);
            m = $urandom_range(0, 2);
            run(n, l, m, 8000 * n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
